// File: rtl/nand_seq_driver.sv
// Command sequencer driving nand_master through bring-up, ID, status and page-read flow.
// Build macro NSEQ_ID_CHECK_EN enables the {ID1,ID0} check against EXPECT_ID (error code 2).
module nand_seq_driver #(
  parameter int unsigned ID_BYTES       = 5,
  parameter int unsigned PAGE_BYTES     = 16,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CE_W           = 8,
  parameter logic [15:0] EXPECT_ID      = 16'hE52C
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            start,
  input  logic            abort,
  input  logic [CE_W-1:0] ce_sel,
  input  logic            nm_busy,
  input  logic [7:0]      nm_data_out,
  output logic [5:0]      nm_cmd,
  output logic [7:0]      nm_data_in,
  output logic            nm_activate,
  output logic            seq_busy,
  output logic            res_valid,
  output logic [1:0]      res_tag,
  output logic [11:0]     res_index,
  output logic [7:0]      res_data,
  output logic            done,
  output logic [1:0]      error_code
);

  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned CW  = 12;
  localparam int unsigned STW = 4;

  localparam logic [STW-1:0] ID_STEP   = STW'(4);
  localparam logic [STW-1:0] LAST_STEP = STW'(9);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_CAPTURE, S_NEXT, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic [5:0] cmd;
    logic [7:0] data;
  } cmd_t;

  // Command and data_in for each step of the flow.
  function automatic cmd_t step_cmd(input logic [STW-1:0] s, input logic [7:0] ce);
    cmd_t c;
    c.cmd  = 6'h00;
    c.data = 8'h00;
    case (s)
      STW'(0): c.cmd = 6'h01;
      STW'(1): begin c.cmd = 6'h0E; c.data = ce; end
      STW'(2): c.cmd = 6'h04;
      STW'(3): c.cmd = 6'h06;
      STW'(4): c.cmd = 6'h13;
      STW'(5): c.cmd = 6'h0D;
      STW'(6): c.cmd = 6'h12;
      STW'(7): c.cmd = 6'h09;
      STW'(8): c.cmd = 6'h12;
      STW'(9): c.cmd = 6'h15;
      default: c.cmd = 6'h00;
    endcase
    return c;
  endfunction

  // {capture, tag} for each step.
  function automatic logic [2:0] step_capture(input logic [STW-1:0] s);
    case (s)
      STW'(4): return 3'b1_00;
      STW'(5): return 3'b1_01;
      STW'(9): return 3'b1_10;
      default: return 3'b0_00;
    endcase
  endfunction

  // Final count value of each step (repeat count minus one).
  function automatic logic [CW-1:0] step_last(input logic [STW-1:0] s);
    case (s)
      STW'(4): return CW'(ID_BYTES - 1);
      STW'(9): return CW'(PAGE_BYTES - 1);
      default: return CW'(0);
    endcase
  endfunction

  state_t          state;
  logic [STW-1:0]  step;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer;
  logic [SW-1:0]   settle_cnt;

  logic [7:0]      ce_byte;
  logic            last_rep;
  logic [STW-1:0]  nxt_step;
  logic [CW-1:0]   nxt_count;
  cmd_t            issue;
  logic [2:0]      cap_info;
  logic            in_flight;
  logic            id_bad;

  assign ce_byte = 8'(ce_sel);

  // Next step/count and the command loaded on the way into ISSUE.
  always_comb begin
    last_rep  = (count == step_last(step));
    nxt_step  = last_rep ? step + STW'(1) : step;
    nxt_count = last_rep ? CW'(0) : count + CW'(1);
    issue     = step_cmd((state == S_IDLE) ? STW'(0) : nxt_step, ce_byte);
    cap_info  = step_capture(step);
    in_flight = (state == S_ISSUE) || (state == S_SETTLE) || (state == S_WAIT) ||
                (state == S_CAPTURE) || (state == S_NEXT);
  end

`ifdef NSEQ_ID_CHECK_EN
  logic [7:0] id0;
  logic [7:0] id1;

  // First two ID bytes retained for the end-of-step comparison.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      id0 <= 8'h00;
      id1 <= 8'h00;
    end else if (state == S_CAPTURE && step == ID_STEP) begin
      if (count == CW'(0)) id0 <= nm_data_out;
      if (count == CW'(1)) id1 <= nm_data_out;
    end
  end

  assign id_bad = (ID_BYTES < 2) ? (id0 != EXPECT_ID[7:0]) : ({id1, id0} != EXPECT_ID);
`else
  logic unused_expect_id;
  assign unused_expect_id = ^EXPECT_ID;
  assign id_bad = 1'b0;
`endif

  // Sequencer FSM with registered outputs; abort overrides every in-flight state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      step        <= STW'(0);
      count       <= CW'(0);
      timer       <= TW'(0);
      settle_cnt  <= SW'(0);
      nm_cmd      <= 6'h00;
      nm_data_in  <= 8'h00;
      nm_activate <= 1'b0;
      seq_busy    <= 1'b0;
      res_valid   <= 1'b0;
      res_tag     <= 2'd0;
      res_index   <= 12'd0;
      res_data    <= 8'h00;
      done        <= 1'b0;
      error_code  <= 2'd0;
    end else begin
      nm_activate <= 1'b0;
      res_valid   <= 1'b0;
      done        <= 1'b0;
      if (abort && in_flight) begin
        state      <= S_ERR;
        error_code <= 2'd3;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              error_code  <= 2'd0;
              step        <= STW'(0);
              count       <= CW'(0);
              seq_busy    <= 1'b1;
              nm_cmd      <= issue.cmd;
              nm_data_in  <= issue.data;
              nm_activate <= 1'b1;
              timer       <= TW'(0);
              settle_cnt  <= SW'(0);
              state       <= S_ISSUE;
            end
          end
          S_ISSUE: state <= S_SETTLE;
          S_SETTLE: begin
            if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= S_WAIT;
            else settle_cnt <= settle_cnt + SW'(1);
          end
          S_WAIT: begin
            timer <= timer + TW'(1);
            if (!nm_busy) begin
              state <= cap_info[2] ? S_CAPTURE : S_NEXT;
            end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
              state      <= S_ERR;
              error_code <= 2'd1;
            end
          end
          S_CAPTURE: begin
            res_valid <= 1'b1;
            res_data  <= nm_data_out;
            res_tag   <= cap_info[1:0];
            res_index <= count;
            state     <= S_NEXT;
          end
          S_NEXT: begin
            if (last_rep && step == ID_STEP && id_bad) begin
              state      <= S_ERR;
              error_code <= 2'd2;
            end else if (last_rep && step == LAST_STEP) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              step        <= nxt_step;
              count       <= nxt_count;
              nm_cmd      <= issue.cmd;
              nm_data_in  <= issue.data;
              nm_activate <= 1'b1;
              timer       <= TW'(0);
              settle_cnt  <= SW'(0);
              state       <= S_ISSUE;
            end
          end
          S_DONE, S_ERR: begin
            seq_busy <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nand_seq_driver.sv
// Directed bench for nand_seq_driver with a small nand_master responder model.
module tb_nand_seq_driver;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start;
  logic        abort;
  logic [7:0]  ce_sel;
  logic        nm_busy;
  logic [7:0]  nm_data_out;
  logic [5:0]  nm_cmd;
  logic [7:0]  nm_data_in;
  logic        nm_activate;
  logic        seq_busy;
  logic        res_valid;
  logic [1:0]  res_tag;
  logic [11:0] res_index;
  logic [7:0]  res_data;
  logic        done;
  logic [1:0]  error_code;

  int n_tests = 0;
  int n_fail  = 0;

  nand_seq_driver #(
    .ID_BYTES(5), .PAGE_BYTES(16), .SETTLE_CYCLES(2),
    .TIMEOUT_CYCLES(100), .CE_W(8), .EXPECT_ID(16'hE52C)
  ) dut (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort), .ce_sel(ce_sel),
    .nm_busy(nm_busy), .nm_data_out(nm_data_out), .nm_cmd(nm_cmd),
    .nm_data_in(nm_data_in), .nm_activate(nm_activate), .seq_busy(seq_busy),
    .res_valid(res_valid), .res_tag(res_tag), .res_index(res_index),
    .res_data(res_data), .done(done), .error_code(error_code)
  );

  always #5 clk = ~clk;

  // nand_master responder: busy for a few cycles per command, optional stuck busy.
  logic       stuck;
  logic [5:0] stuck_cmd;
  logic [7:0] id_tbl [5];
  int         id_idx, pg_idx, bcnt;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nm_busy <= 1'b0; bcnt <= 0; nm_data_out <= 8'h00; id_idx <= 0; pg_idx <= 0;
    end else if (nm_activate) begin
      nm_busy <= 1'b1;
      bcnt    <= (nm_cmd == 6'h09) ? 8 : 3;
      case (nm_cmd)
        6'h06: id_idx <= 0;
        6'h13: begin nm_data_out <= id_tbl[id_idx % 5]; id_idx <= id_idx + 1; end
        6'h0D: nm_data_out <= 8'hE0;
        6'h12: pg_idx <= 0;
        6'h15: begin nm_data_out <= 8'(8'hA0 + pg_idx); pg_idx <= pg_idx + 1; end
        default: ;
      endcase
    end else if (nm_busy && !(stuck && nm_cmd == stuck_cmd)) begin
      if (bcnt <= 1) nm_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  // Output monitor, sampled on the falling edge.
  logic [5:0]  cmd_q [$];
  logic [7:0]  din_q [$];
  logic [1:0]  tag_q [$];
  logic [11:0] idx_q [$];
  logic [7:0]  dat_q [$];
  int cyc = 0, act_cyc = 0, err_cyc = -1, done_cnt = 0, pg_cnt = 0, st_cnt = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (nm_activate) begin
      cmd_q.push_back(nm_cmd);
      din_q.push_back(nm_data_in);
      act_cyc = cyc;
      if (nm_cmd == 6'h15) pg_cnt = pg_cnt + 1;
      if (nm_cmd == 6'h0D) st_cnt = st_cnt + 1;
    end
    if (res_valid) begin
      tag_q.push_back(res_tag);
      idx_q.push_back(res_index);
      dat_q.push_back(res_data);
    end
    if (done) done_cnt = done_cnt + 1;
    if (error_code != 2'd0 && err_cyc < 0) err_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cmd_q.delete(); din_q.delete(); tag_q.delete(); idx_q.delete(); dat_q.delete();
    err_cyc = -1; done_cnt = 0; pg_cnt = 0; st_cnt = 0;
  endtask

  task automatic do_reset();
    nreset = 1'b0; start = 1'b0; abort = 1'b0; stuck = 1'b0;
    repeat (2) tick();
    clear_logs();
    nreset = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(seq_busy), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (seq_busy && n < max_cyc) begin tick(); n++; end
    check("wait_idle", 32'(seq_busy), 32'd0);
  endtask

  function automatic logic [5:0] exp_cmd(input int i);
    if (i == 0) return 6'h01;
    if (i == 1) return 6'h0E;
    if (i == 2) return 6'h04;
    if (i == 3) return 6'h06;
    if (i < 9) return 6'h13;
    if (i == 9) return 6'h0D;
    if (i == 10 || i == 12) return 6'h12;
    if (i == 11) return 6'h09;
    return 6'h15;
  endfunction

  // Expected {tag, index, data} of result i in a nominal run with ID 2C,E5,FF,03,86.
  function automatic logic [21:0] exp_res(input int i);
    logic [7:0] ids [5];
    ids = '{8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86};
    if (i < 5) return {2'd0, 12'(i), ids[i]};
    if (i == 5) return {2'd1, 12'd0, 8'hE0};
    return {2'd2, 12'(i - 6), 8'(8'hA0 + i - 6)};
  endfunction

  task automatic verify_nominal(input string name);
    check({name, "_strobes"}, 32'(cmd_q.size()), 32'd29);
    for (int i = 0; i < 29 && i < cmd_q.size(); i++)
      check({name, "_cmd"}, 32'(cmd_q[i]), 32'(exp_cmd(i)));
    check({name, "_results"}, 32'(tag_q.size()), 32'd22);
    for (int i = 0; i < 22 && i < tag_q.size(); i++)
      check({name, "_res"}, 32'({tag_q[i], idx_q[i], dat_q[i]}), 32'(exp_res(i)));
    check({name, "_done"}, 32'(done_cnt), 32'd1);
    check({name, "_err"}, 32'(error_code), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nreset = 1'b0; start = 1'b0; abort = 1'b0; ce_sel = 8'h00;
    stuck = 1'b0; stuck_cmd = 6'h00;
    id_tbl = '{8'h2C, 8'hE5, 8'hFF, 8'h03, 8'h86};
    repeat (2) tick();
    check("rst_outputs", 32'({nm_cmd, nm_data_in, nm_activate, seq_busy, res_valid}), 32'd0);
    check("rst_res", 32'({res_tag, res_index, res_data, done, error_code}), 32'd0);

    // Nominal flow.
    do_reset();
    pulse_start();
    wait_idle(3000);
    verify_nominal("nominal");
    check("nominal_ce_data", 32'(din_q.size() > 1 ? din_q[1] : 8'hXX), 32'h00);

    // Busy stuck during M_NAND_RESET: timeout 100 cycles after WAIT entry.
    do_reset();
    stuck = 1'b1; stuck_cmd = 6'h04;
    pulse_start();
    wait_idle(3000);
    check("to_err", 32'(error_code), 32'd1);
    check("to_latency", 32'(err_cyc - act_cyc), 32'd103);
    repeat (20) tick();
    check("to_strobes", 32'(cmd_q.size()), 32'd3);
    check("to_done", 32'(done_cnt), 32'd0);

    // Abort during 7th page-byte fetch.
    do_reset();
    pulse_start();
    n = 0;
    while (pg_cnt < 7 && n < 3000) begin tick(); n++; end
    check("ab_reached", 32'(pg_cnt), 32'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_err", 32'(error_code), 32'd3);
    tick();
    check("ab_busy", 32'(seq_busy), 32'd0);
    check("ab_last_idx", 32'(idx_q.size() > 0 ? idx_q[idx_q.size()-1] : 12'hFFF), 32'd5);
    check("ab_results", 32'(tag_q.size()), 32'd12);
    repeat (10) tick();
    check("ab_strobes", 32'(cmd_q.size()), 32'd20);
    check("ab_done", 32'(done_cnt), 32'd0);

    // Reset in the WAIT of M_NAND_READ, then a full rerun.
    do_reset();
    ce_sel = 8'h3C;
    pulse_start();
    n = 0;
    while (!(cmd_q.size() == 12) && n < 3000) begin tick(); n++; end
    repeat (4) tick();
    check("mid_cmd", 32'(nm_cmd), 32'h09);
    check("mid_busy", 32'(seq_busy), 32'd1);
    nreset = 1'b0;
    #1;
    check("mid_rst_a", 32'({nm_cmd, nm_data_in, nm_activate, seq_busy, res_valid}), 32'd0);
    check("mid_rst_b", 32'({res_tag, res_index, res_data, done, error_code}), 32'd0);
    tick();
    clear_logs();
    nreset = 1'b1;
    tick();
    pulse_start();
    wait_idle(3000);
    check("rerun_strobes", 32'(cmd_q.size()), 32'd29);
    check("rerun_first", 32'(cmd_q.size() > 0 ? cmd_q[0] : 6'h3F), 32'h01);
    check("rerun_ce_data", 32'(din_q.size() > 1 ? din_q[1] : 8'hXX), 32'h3C);
    check("rerun_done", 32'(done_cnt), 32'd1);
    ce_sel = 8'h00;

    // Start pulses while busy are ignored.
    do_reset();
    pulse_start();
    n = 0;
    while (seq_busy && n < 3000) begin
      start = (n == 20 || n == 60 || n == 150) ? 1'b1 : 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    check("ign_idle", 32'(seq_busy), 32'd0);
    verify_nominal("ignore_start");

    // ID mismatch: device reports 98,DA against expected E52C.
    do_reset();
    id_tbl = '{8'h98, 8'hDA, 8'hFF, 8'h03, 8'h86};
    pulse_start();
    wait_idle(3000);
    check("idc_id_results", 32'(tag_q.size() >= 5 ? {tag_q[4], idx_q[4], dat_q[4]} : 22'h3FFFFF),
          32'({2'd0, 12'd4, 8'h86}));
`ifdef NSEQ_ID_CHECK_EN
    check("idc_err", 32'(error_code), 32'd2);
    check("idc_results", 32'(tag_q.size()), 32'd5);
    check("idc_status_strobes", 32'(st_cnt), 32'd0);
    check("idc_strobes", 32'(cmd_q.size()), 32'd9);
    check("idc_done", 32'(done_cnt), 32'd0);
`else
    check("idc_err", 32'(error_code), 32'd0);
    check("idc_status_strobes", 32'(st_cnt), 32'd1);
    check("idc_strobes", 32'(cmd_q.size()), 32'd29);
    check("idc_done", 32'(done_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
